// File: rtl/inv_sbytes_seq_if.sv
// Valid/ready handshake bundle for inv_sbytes_seq: one state in, one substituted state out.
interface inv_sbytes_seq_if #(
    parameter int unsigned NWords = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32*NWords-1:0]  state_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*NWords-1:0]  state_out;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out
    );
endinterface

// File: rtl/inv_sbytes_seq.sv
// AES inverse SubBytes, BYTES_PER_CYCLE shared inverse S-box lookups per clock.
// Optional INV_SBYTES_PERF_CNT_EN adds a 16-bit completed-block counter output blk_count.
module inv_sbytes_seq #(
    parameter int unsigned NWords          = 4,
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_sbytes_seq_if.slave       bus
`ifdef INV_SBYTES_PERF_CNT_EN
    ,
    output logic [15:0]           blk_count
`endif
);

    localparam int unsigned W       = 32 * NWords;
    localparam int unsigned NBytes  = 4 * NWords;
    localparam int unsigned GrpW    = 8 * BYTES_PER_CYCLE;
    localparam int unsigned IdxW    = $clog2(NBytes) + 1;
    localparam int unsigned LastIdx = NBytes - BYTES_PER_CYCLE;

    // Element 0 is the most significant byte, so the table reads in FIPS-197 order.
    localparam logic [0:255][7:0] InvSboxTbl = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q;
    logic [W-1:0]        work_q;
    logic [IdxW-1:0]     idx_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [W-1:0]        state_out_q;

    logic [IdxW+2:0]     shamt;
    logic [GrpW-1:0]     grp_in;
    logic [GrpW-1:0]     grp_out;
    logic [W-1:0]        grp_mask;
    logic [W-1:0]        grp_ext;
    logic [W-1:0]        work_sub;

    // Align the active group to the top of the word, substitute, then shift it back.
    always_comb begin
        shamt    = {idx_q, 3'b000};
        grp_in   = GrpW'((work_q << shamt) >> (W - GrpW));
        grp_out  = '0;
        for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
            grp_out[GrpW-1-8*j -: 8] = InvSboxTbl[grp_in[GrpW-1-8*j -: 8]];
        end
        grp_mask = (W'({GrpW{1'b1}}) << (W - GrpW)) >> shamt;
        grp_ext  = (W'(grp_out) << (W - GrpW)) >> shamt;
        work_sub = (work_q & ~grp_mask) | grp_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            work_q      <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            state_out_q <= '0;
`ifdef INV_SBYTES_PERF_CNT_EN
            blk_count   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.state_in;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    work_q <= work_sub;
                    idx_q  <= idx_q + IdxW'(BYTES_PER_CYCLE);
                    if (idx_q == IdxW'(LastIdx)) begin
                        state_out_q <= work_sub;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
`ifdef INV_SBYTES_PERF_CNT_EN
                        blk_count   <= blk_count + 16'd1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.state_out = state_out_q;

endmodule

// File: doc/inv_sbytes_seq.md
Name: inv_sbytes_seq

Overview:
- Inverse SubBytes stage for the AES-128 decrypt datapath; the counterpart of the encrypt-side SBytes block.
- Accepts one 128-bit state over a valid/ready handshake and substitutes every byte through the AES inverse S-box.
- Processes BYTES_PER_CYCLE bytes per clock through shared inverse S-box LUTs to save area.
- Presents the result on a valid/ready output held until accepted; sits between InvShiftRows and AddRoundKey in the decrypt round.

Parameters:
- NWords, 4, number of 32-bit words in the state; state width = 32*NWords.
- BYTES_PER_CYCLE, 4, inverse S-box lookups per clock; legal values 1, 2, 4, 8, 16 (must divide 4*NWords).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept a state.
- state_in  input  32*NWords  ciphertext-side state; byte 0 = state_in[MSB -: 8].
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  32*NWords  inverse-substituted state, same byte order as the input.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, in_ready=1, out_valid=0, state_out=0, byte index=0, internal working register=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture state_in into the working register, idx=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle replace bytes idx..idx+BYTES_PER_CYCLE-1 with InvSbox(byte); idx += BYTES_PER_CYCLE. On the cycle that processes the final group, load state_out and go to DONE.
  - DONE: out_valid=1; state_out stable. On out_ready, go to IDLE, out_valid=0 next cycle.
- Latency: accept edge to out_valid = 4*NWords/BYTES_PER_CYCLE cycles (4 with defaults, 16 with BYTES_PER_CYCLE=1).
- Throughput: one state per latency+1 cycles when out_ready is held high. There is no accept in the same cycle that the output is consumed; in_ready returns in the cycle after the out_ready handshake.
- in_valid while BUSY or DONE is ignored; no buffering, no overwrite.
- out_ready while not DONE has no effect.
- idx width = clog2(4*NWords)+1; idx never wraps inside a block and resets to 0 on every accept.
- Reset asserted mid-BUSY or mid-DONE aborts the block: partial results are discarded and out_valid drops immediately (asynchronously).
- Inverse S-box is the standard FIPS-197 table; it must satisfy InvSbox(Sbox(x))=x for all 256 x. Examples: InvSbox(0x63)=0x00, InvSbox(0x00)=0x52.

Optional Feature:
- Macro INV_SBYTES_PERF_CNT_EN.
- Defined: adds output blk_count (16 bits), reset to 0. It increments by 1 on every out_valid&out_ready handshake and wraps 0xFFFF->0x0000.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then in_valid with state_in=128'hd42711aee0bf98f1b8b45de51e415230, out_ready=1 -> out_valid rises 4 cycles after accept with state_out=128'h193de3bea0f4e22b9ac68d2ae9f84808.
- state_in=128'h0 -> state_out=128'h52525252525252525252525252525252; state_in all 0x63 -> state_out=128'h0.
- Hold out_ready=0 for 10 cycles after completion -> out_valid stays 1, state_out stable, in_ready stays 0, and a second in_valid is ignored. Raise out_ready -> in_ready=1 the next cycle.
- Drive rst_n=0 two cycles into BUSY -> out_valid=0 and in_ready=1 immediately. A new block after release gives the correct result with full latency.
- BYTES_PER_CYCLE=1: first test vector -> result after exactly 16 cycles. Also feed all 256 byte values through chained SBytes->inv_sbytes_seq -> output equals input.
- With INV_SBYTES_PERF_CNT_EN: 3 back-to-back blocks -> blk_count=3. Preload near wrap -> 0xFFFF+1 gives 0x0000.
